hci_tcdm_bank_target: RTL and testbench

//  Memory-side end of the HCI core protocol. Acts as target for one hci_core port driven by a router/interconnect initiator.

---
 rtl/hci_tcdm_bank_target.sv | 140 ++++++++++++++
 tb/tb_hci_tcdm_bank_target.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_tcdm_bank_target.sv
// ============================================================================
// Module   : hci_tcdm_bank_target
// Function : HCI core target bank: byte-enabled storage, 1-cycle reads,
//            credit-based response FIFO. Optional macro HCI_BANK_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hci_tcdm_bank_target #(
  parameter int unsigned NB_WORDS             = 1024,
  parameter int unsigned DW                   = 32,
  parameter int unsigned AW                   = 32,
  parameter int unsigned IW                   = 8,
  parameter int unsigned RESP_DEPTH           = 2,
  parameter int unsigned FILTER_WRITE_R_VALID = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               tcdm_req_i,
  output logic               tcdm_gnt_o,
  input  logic [AW-1:0]      tcdm_add_i,
  input  logic               tcdm_wen_i,
  input  logic [DW/8-1:0]    tcdm_be_i,
  input  logic [DW-1:0]      tcdm_data_i,
  input  logic [IW-1:0]      tcdm_id_i,
  output logic [DW-1:0]      tcdm_r_data_o,
  output logic [IW-1:0]      tcdm_r_id_o,
  output logic               tcdm_r_valid_o,
  input  logic               tcdm_r_ready_i,
  output logic               tcdm_r_err_o
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned OFF_W = $clog2(BW);
  localparam int unsigned IDX_W = $clog2(NB_WORDS);
  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned REP   = (DW + 31) / 32;
  localparam logic [REP*32-1:0] C_ERR_PAT_FULL = {REP{32'hBADCAB1E}};
  localparam logic [DW-1:0]     C_ERR_PAT      = C_ERR_PAT_FULL[DW-1:0];

  logic [DW-1:0]    r_mem       [NB_WORDS];
  logic [DW-1:0]    r_fifo_data [RESP_DEPTH];
  logic [IW-1:0]    r_fifo_id   [RESP_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_hs;
  logic             w_push;
  logic             w_pop;
  logic             w_oor;
  logic [DW-1:0]    w_rsp_data;
  logic             w_unused_add;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_idx        = tcdm_add_i[OFF_W +: IDX_W];
  assign w_unused_add = ^tcdm_add_i;

  // Grant depends on registered credit count only.
  assign tcdm_gnt_o     = (r_cnt < CNT_W'(RESP_DEPTH));
  assign tcdm_r_valid_o = (r_cnt != '0);
  assign w_hs           = tcdm_req_i & tcdm_gnt_o;
  assign w_push         = w_hs & (tcdm_wen_i | (FILTER_WRITE_R_VALID == 0));
  assign w_pop          = tcdm_r_valid_o & tcdm_r_ready_i;

`ifdef HCI_BANK_RANGE_CHECK_EN
  logic r_fifo_err [RESP_DEPTH];

  assign w_oor = |(tcdm_add_i >> (OFF_W + IDX_W));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_err[r_wptr] <= w_oor;
    end
  end

  assign tcdm_r_err_o = tcdm_r_valid_o ? r_fifo_err[r_rptr] : 1'b0;
`else
  assign w_oor        = 1'b0;
  assign tcdm_r_err_o = 1'b0;
`endif

  assign w_rsp_data = !tcdm_wen_i ? '0 :
                      w_oor       ? C_ERR_PAT : r_mem[w_idx];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_hs && !tcdm_wen_i && !w_oor) begin
      for (int j = 0; j < BW; j++) begin
        if (tcdm_be_i[j]) begin
          r_mem[w_idx][8*j +: 8] <= tcdm_data_i[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_rsp_data;
      r_fifo_id[r_wptr]   <= tcdm_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign tcdm_r_data_o = tcdm_r_valid_o ? r_fifo_data[r_rptr] : '0;
  assign tcdm_r_id_o   = tcdm_r_valid_o ? r_fifo_id[r_rptr]   : '0;

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && r_cnt == CNT_W'(RESP_DEPTH)));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_pop && r_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_hci_tcdm_bank_target.sv
// Testbench for hci_tcdm_bank_target: reference-model scoreboard over a
// response-returning bank (a) and a write-filtering bank (b).
`default_nettype none

module tb_hci_tcdm_bank_target;

  localparam int          NBW   = 16;
  localparam logic [31:0] C_PAT = 32'hBADCAB1E;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  id;
    logic        e;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  id = '0;
  logic        r_ready = 1'b0;

  logic        gnt_a, gnt_b, rv_a, rv_b, rerr_a, rerr_b;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  rid_a, rid_b;

  always #5 clk = ~clk;

  hci_tcdm_bank_target #(
    .NB_WORDS(NBW), .DW(32), .AW(32), .IW(8), .RESP_DEPTH(2), .FILTER_WRITE_R_VALID(0)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req_a), .tcdm_gnt_o(gnt_a), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_id_i(id),
    .tcdm_r_data_o(rd_a), .tcdm_r_id_o(rid_a), .tcdm_r_valid_o(rv_a),
    .tcdm_r_ready_i(r_ready), .tcdm_r_err_o(rerr_a)
  );

  hci_tcdm_bank_target #(
    .NB_WORDS(NBW), .DW(32), .AW(32), .IW(8), .RESP_DEPTH(2), .FILTER_WRITE_R_VALID(1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req_b), .tcdm_gnt_o(gnt_b), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_id_i(id),
    .tcdm_r_data_o(rd_b), .tcdm_r_id_o(rid_b), .tcdm_r_valid_o(rv_b),
    .tcdm_r_ready_i(r_ready), .tcdm_r_err_o(rerr_b)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  bit   auto_rdy = 1'b0;
  rsp_t qa[$];
  rsp_t qb[$];
  logic [31:0] ma [NBW];
  logic [31:0] mb [NBW];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: word = address / 4 modulo depth; upper bits alias or error.
  task automatic model_accept(input bit sel, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic [7:0] i);
    rsp_t r;
    int   ix;
    bit   oor;
    ix  = int'((a / 4) % NBW);
    oor = 1'b0;
`ifdef HCI_BANK_RANGE_CHECK_EN
    oor = (a / (4 * NBW)) != 0;
`endif
    r.id = i;
    r.e  = oor;
    if (w) begin
      r.d = oor ? C_PAT : (sel ? mb[ix] : ma[ix]);
      if (sel) qb.push_back(r);
      else     qa.push_back(r);
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (b[j] && !oor) begin
          if (sel) mb[ix][8*j +: 8] = d[8*j +: 8];
          else     ma[ix][8*j +: 8] = d[8*j +: 8];
        end
      end
      r.d = '0;
      if (!sel) qa.push_back(r);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic issue(input bit sel, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [7:0] i,
                       output int waits);
    add = a; wen = w; be = b; wdata = d; id = i;
    if (sel) req_b = 1'b1;
    else     req_a = 1'b1;
    waits = 0;
    while (!(sel ? gnt_b : gnt_a) && waits < 50) begin
      if (auto_rdy) r_ready = 1'b1;
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      chk("grant_timeout", 32'(waits), 32'd0);
    end else begin
      @(posedge clk);
      model_accept(sel, w, a, b, d, i);
      @(negedge clk);
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare the FIFO head against the scoreboard every cycle it is valid.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (rv_a) begin
          if (qa.size() == 0) chk("a_spurious_rvalid", 32'(rv_a), 32'd0);
          else begin
            chk("a_rdata", rd_a, qa[0].d);
            chk("a_rid", 32'(rid_a), 32'(qa[0].id));
            chk("a_rerr", 32'(rerr_a), 32'(qa[0].e));
            if (r_ready) void'(qa.pop_front());
          end
        end
        if (rv_b) begin
          if (qb.size() == 0) chk("b_spurious_rvalid", 32'(rv_b), 32'd0);
          else begin
            chk("b_rdata", rd_b, qb[0].d);
            chk("b_rid", 32'(rid_b), 32'(qb[0].id));
            chk("b_rerr", 32'(rerr_b), 32'(qb[0].e));
            if (r_ready) void'(qb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int          w;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_gnt_a", 32'(gnt_a), 32'd1);
    chk("reset_rvalid_a", 32'(rv_a), 32'd0);
    chk("reset_rdata_a", rd_a, 32'd0);
    chk("reset_rerr_a", 32'(rerr_a), 32'd0);
    chk("reset_gnt_b", 32'(gnt_b), 32'd1);
    chk("reset_rvalid_b", 32'(rv_b), 32'd0);

    // Fill both arrays with known contents.
    r_ready = 1'b1;
    for (int i = 0; i < NBW; i++) begin
      issue(1'b0, 1'b0, 32'(i * 4), 4'hF, $urandom, 8'(i), w);
      issue(1'b1, 1'b0, 32'(i * 4), 4'hF, $urandom, 8'(i), w);
    end
    idle(3);

    // Partial byte-enable write, then read with one-cycle latency.
    issue(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 8'h20, w);
    issue(1'b0, 1'b0, 32'h10, 4'b0101, 32'hAABBCCDD, 8'h21, w);
    idle(3);
    r_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 8'h22, w);
    chk("be_read_valid", 32'(rv_a), 32'd1);
    chk("be_read_data", rd_a, 32'h00BB00DD);
    r_ready = 1'b1;
    idle(2);

    // Back-to-back reads at full throughput.
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 1'b1, 32'(k * 4), 4'h0, 32'h0, 8'(k + 1), w);
      chk("throughput_waits", 32'(w), 32'd0);
    end
    idle(3);

    // Backpressure: exactly two credits, then grant drops until a pop.
    r_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 8'h31, w);
    chk("bp_first_waits", 32'(w), 32'd0);
    issue(1'b0, 1'b1, 32'h24, 4'h0, 32'h0, 8'h32, w);
    chk("bp_second_waits", 32'(w), 32'd0);
    add = 32'h28; wen = 1'b1; req_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_gnt_low", 32'(gnt_a), 32'd0);
      @(negedge clk);
    end
    req_a = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk("bp_gnt_back", 32'(gnt_a), 32'd1);
    r_ready = 1'b1;
    idle(3);

    // Filtered writes take no credit and return nothing.
    r_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue(1'b1, 1'b0, 32'(k * 4), 4'($urandom), $urandom, 8'(k + 8'h40), w);
      chk("filter_write_waits", 32'(w), 32'd0);
    end
    chk("filter_no_rvalid", 32'(rv_b), 32'd0);
    issue(1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 8'h50, w);
    issue(1'b1, 1'b1, 32'h4, 4'h0, 32'h0, 8'h51, w);
    chk("filter_read_waits", 32'(w), 32'd0);
    r_ready = 1'b1;
    idle(3);

    // Synchronous clear with responses pending.
    r_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h8, 4'h0, 32'h0, 8'h60, w);
    issue(1'b0, 1'b1, 32'hC, 4'h0, 32'h0, 8'h61, w);
    clear = 1'b1;
    @(posedge clk);
    qa.delete();
    @(negedge clk);
    clear = 1'b0;
    chk("clear_rvalid", 32'(rv_a), 32'd0);
    chk("clear_gnt", 32'(gnt_a), 32'd1);

    // Asynchronous reset between clock edges.
    issue(1'b0, 1'b1, 32'h8, 4'h0, 32'h0, 8'h70, w);
    issue(1'b0, 1'b1, 32'hC, 4'h0, 32'h0, 8'h71, w);
    #3;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("arst_rvalid", 32'(rv_a), 32'd0);
    chk("arst_gnt", 32'(gnt_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    r_ready = 1'b1;
    idle(2);

`ifdef HCI_BANK_RANGE_CHECK_EN
    r_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h1000, 4'h0, 32'h0, 8'h80, w);
    chk("oor_rdata", rd_a, C_PAT);
    chk("oor_rerr", 32'(rerr_a), 32'd1);
    r_ready = 1'b1;
    issue(1'b0, 1'b0, 32'h1000, 4'hF, 32'h12345678, 8'h81, w);
    issue(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 8'h82, w);
    idle(3);
`endif

    // Randomized traffic on both banks with random backpressure.
    auto_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4 * NBW - 1));
      r_ready = ($urandom_range(0, 3) != 0);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 4'($urandom),
            $urandom, 8'($urandom), w);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    auto_rdy = 1'b0;

    r_ready = 1'b1;
    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
